// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and jump-register hazard detection.
// Optional stall-cycle counter is built when STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    Rs_id,
  input  logic [4:0]    Rt_id,
  input  logic [4:0]    Rd_id,
  input  logic [5:0]    op_id,
  input  logic          Jump_id,
  input  logic          RegWrite_id,
  input  logic          MemWrite_id,
  input  logic          MemRead_id,
  input  logic [DW-1:0] rdata1_id,
  input  logic [DW-1:0] rdata2_id,
  input  logic [DW-1:0] imm_id,
  input  logic [DW-1:0] pc4_id,
  input  logic [4:0]    Rd_mem,
  input  logic          MemRead_mem,
  input  logic          flush_ex,
  output logic          stall_o,
  output logic [4:0]    Rs_ex,
  output logic [4:0]    Rt_ex,
  output logic [4:0]    Rd_ex,
  output logic [5:0]    op_ex,
  output logic          RegWrite_ex,
  output logic          MemWrite_ex,
  output logic          MemRead_ex,
  output logic [DW-1:0] rdata1_ex,
  output logic [DW-1:0] rdata2_ex,
  output logic [DW-1:0] imm_ex,
  output logic [DW-1:0] pc4_ex,
  output logic [31:0]   stall_count
);

  logic uses_rt;
  logic jr_id;
  logic ex_load_rs;
  logic ex_load_rt;
  logic mem_load_rs;
  logic load_use;
  logic jr_hazard;
  logic bubble;

  assign uses_rt     = (op_id == 6'h00) || MemWrite_id || (op_id == 6'h04) || (op_id == 6'h05);
  assign jr_id       = Jump_id && (op_id == 6'h00);
  assign ex_load_rs  = MemRead_ex && (Rd_ex != 5'd0) && (Rd_ex == Rs_id);
  assign ex_load_rt  = MemRead_ex && (Rd_ex != 5'd0) && uses_rt && (Rd_ex == Rt_id);
  assign mem_load_rs = MemRead_mem && (Rd_mem != 5'd0) && (Rd_mem == Rs_id);

  assign load_use  = ex_load_rs || ex_load_rt;
  // jr resolves its target in ID, so a load still in MEM is also too late.
  assign jr_hazard = jr_id && (ex_load_rs || mem_load_rs);

  // Flush outranks stall so the PC is free to take the redirect.
  assign stall_o = (load_use || jr_hazard) && !flush_ex;
  assign bubble  = flush_ex || stall_o;

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {Rs_ex, Rt_ex, Rd_ex, op_ex}            <= '0;
      {RegWrite_ex, MemWrite_ex, MemRead_ex}  <= '0;
      {rdata1_ex, rdata2_ex, imm_ex, pc4_ex}  <= '0;
    end else if (bubble) begin
      {Rs_ex, Rt_ex, Rd_ex, op_ex}            <= '0;
      {RegWrite_ex, MemWrite_ex, MemRead_ex}  <= '0;
      {rdata1_ex, rdata2_ex, imm_ex, pc4_ex}  <= '0;
    end else begin
      Rs_ex       <= Rs_id;
      Rt_ex       <= Rt_id;
      Rd_ex       <= Rd_id;
      op_ex       <= op_id;
      RegWrite_ex <= RegWrite_id;
      MemWrite_ex <= MemWrite_id;
      MemRead_ex  <= MemRead_id;
      rdata1_ex   <= rdata1_id;
      rdata2_ex   <= rdata2_id;
      imm_ex      <= imm_id;
      pc4_ex      <= pc4_id;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_o && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the five-stage pipelined CPU. It captures decoded fields, operands and control from ID and presents them to EX and the forwarding unit. It detects load-use and jump-register-on-load hazards, asserts a stall to PC and IF/ID, and inserts bubbles into EX. Branch/jump flushes from EX clear the stage.

## Interface
- DW, 32, datapath width (operands, immediate, PC+4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Rs_id, Rt_id, Rd_id  in  5 each  source/source/resolved destination from ID (Rd_id already muxed: rd, rt or 31)
- op_id  in  6  opcode in ID
- Jump_id  in  1  ID instruction is a jump (jr/jalr when op_id==0)
- RegWrite_id, MemWrite_id, MemRead_id  in  1 each  decoded control
- rdata1_id, rdata2_id, imm_id, pc4_id  in  DW each  register-file reads, extended immediate, PC+4
- Rd_mem  in  5  destination in MEM
- MemRead_mem  in  1  MEM instruction is a load
- flush_ex  in  1  taken branch/jump resolved in EX; kill the ID instruction
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- Rs_ex, Rt_ex, Rd_ex  out  5 each  registered fields to EX/forwarding
- op_ex  out  6  registered opcode
- RegWrite_ex, MemWrite_ex, MemRead_ex  out  1 each  registered control
- rdata1_ex, rdata2_ex, imm_ex, pc4_ex  out  DW each  registered data
- stall_count  out  32  stall-cycle counter (only with STALL_CNT_EN)

## Operation
- uses_rt = (op_id==0) || MemWrite_id || op_id==6'h04 || op_id==6'h05.
- jr_id = Jump_id && op_id==0.
- Load-use hazard: MemRead_ex && Rd_ex!=0 && (Rd_ex==Rs_id || (uses_rt && Rd_ex==Rt_id)).
- Jump-register hazard: jr_id && ((MemRead_ex && Rd_ex!=0 && Rd_ex==Rs_id) || (MemRead_mem && Rd_mem!=0 && Rd_mem==Rs_id)).
- stall_o = (load-use || jump-register hazard) && !flush_ex.
- Register update at each clk edge, priority high to low:
  1. flush_ex: load bubble.
  2. stall_o: load bubble (ID instruction stays in IF/ID, re-evaluated next cycle).
  3. else: capture all *_id inputs.
- Bubble: all five-bit fields 0, op_ex 0, all control bits 0, data outputs 0. With RegWrite_ex=0 and Rd_ex=0 a bubble never matches forwarding.
- No explicit FSM: multi-cycle stalls come from re-evaluation. jr after load in EX stalls 2 cycles: load in EX, then load in MEM. jr after load in MEM stalls 1 cycle. ALU producers never stall; they are forwarded downstream.
- Reset mid-operation: all registered outputs and stall_count clear immediately. stall_o follows its inputs: it is 0 after reset because MemRead_ex is 0, unless MemRead_mem matches.

## Timing
- Reset values: every registered output 0; stall_count 0.
- Latency: 1 cycle ID→EX. stall_o has zero-cycle combinational latency from *_id, *_ex (registered) and *_mem.
- flush_ex and stall_o in the same cycle: flush wins, stall_o forced 0, so the PC can take the redirect.
- Back-to-back stalls each insert one bubble per cycle. The ID instruction enters EX on the first cycle stall_o is low.

## Configuration
- STALL_CNT_EN defined:
  - stall_count increments by 1 on every clk edge where stall_o=1.
  - It saturates at 32'hFFFFFFFF and is cleared by rst.
- STALL_CNT_EN undefined:
  - stall_count is tied to 0 and no counter flops exist.

## Test plan
- Load-use: lw $2 in EX (MemRead_ex=1, Rd_ex=2), add with Rs_id=2 in ID.
  - stall_o=1 for one cycle; next EX is a bubble (RegWrite_ex=0, Rd_ex=0).
  - Following cycle the add is captured (Rs_ex=2); stall_count +1.
- Rt not used: lw $3 in EX, addi with Rt_id=3 (op 6'h08, uses_rt=0) → stall_o=0, no bubble.
- jr after load:
  - lw $31 in EX, jr with Rs_id=31 → stall_o=1 two consecutive cycles (EX match, then MemRead_mem/Rd_mem=31 match).
  - jr enters EX on the third cycle; stall_count +2.
- Flush priority: load-use hazard present and flush_ex=1 → stall_o=0; next EX is a bubble, not the ID instruction.
- $zero: lw $0 in EX with Rs_id=0 → no stall.
- Reset: assert rst asynchronously mid-capture → all EX outputs 0 before the next clk edge; stall_count 0.
